// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose: bundles every handshake and bus signal of the two-port memory
// arbiter. The three groups are:
//   - the instruction-fetch port (if_*)
//   - the load/store data port (d_*)
//   - the single-ported memory (mem_*)
// Signal names keep their _i/_o suffixes as seen from the arbiter, so
// waveforms read the same at either end of the interface.
//
// Parameters:
//   AW - address width
//   DW - data width
//
// Modports:
//   slave  - the arbiter's view. Requests and memory read data come in;
//            grants, read responses and the memory command go out.
//   master - the environment's view (requesters plus memory); every
//            direction is the mirror of slave.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Fetch port
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;

  // Data (load/store) port
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;

  // Memory side; read data returns one cycle after mem_rd_o
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one single-ported memory between an instruction-fetch port
// and a load/store data port.
//   - At most one request is granted per cycle.
//   - The grant is combinational, so a request is accepted in the same cycle
//     it is raised.
//   - The granted port drives the memory command in that same cycle.
//   - The data port normally wins a tie. The fetch port is denied at most
//     STARVE_MAX consecutive cycles; the next cycle it is forced through.
//   - Each granted read records which port owns it. One cycle later the
//     owner gets a single-cycle rvalid carrying mem_rdata_i.
//   - Writes complete at their grant and never produce an rvalid.
//
// Parameters:
//   AW         - address width; must match the connected interface
//   DW         - data width; must match the connected interface
//   STARVE_MAX - max consecutive denied cycles for a requesting fetch port
//                (1..15)
//
// Ports:
//   clk_i - single clock; all state updates on the rising edge
//   rst_i - synchronous, active-high reset. It also gates every grant,
//           memory strobe and response combinationally while high.
//   bus   - mem_arbiter_if.slave carrying:
//             fetch port:  if_req/addr/gnt/rvalid/rdata
//             data port:   d_req/we/addr/wdata/gnt/rvalid/rdata
//             memory side: mem_addr/rd/wr/wdata/rdata
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  // 4 bits covers the full 1..15 range of STARVE_MAX.
  localparam int             CW         = 4;
  localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);
  localparam int             NPORT      = 2;

  // Which requester a pending read belongs to. The enum value doubles as
  // the port index used by the per-port response logic below.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] starve_reg, starve_next;
  logic          pend_valid_reg, pend_valid_next;
  owner_e        pend_owner_reg, pend_owner_next;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic fetch_forced;
  logic fetch_gnt;
  logic data_gnt;
  logic read_gnt;

  always_comb begin
    fetch_forced = (starve_reg == STARVE_LIM);
    fetch_gnt    = 1'b0;
    data_gnt     = 1'b0;
    if (!rst_i) begin
      // The data port loses a tie only once the fetch port has already
      // been starved for the maximum allowed number of cycles.
      if (bus.d_req_i && !(bus.if_req_i && fetch_forced)) begin
        data_gnt = 1'b1;
      end else if (bus.if_req_i) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  assign read_gnt = fetch_gnt || (data_gnt && !bus.d_we_i);

  // ---------------------------------------------------------------------------
  // Memory command, steered from whichever port won this cycle.
  // Address and write data are zeroed when idle, so the bus is quiet.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_rd_o    = 1'b0;
    bus.mem_wr_o    = 1'b0;
    bus.mem_wdata_o = '0;
    if (data_gnt) begin
      bus.mem_addr_o = bus.d_addr_i;
      if (bus.d_we_i) begin
        bus.mem_wr_o    = 1'b1;
        bus.mem_wdata_o = bus.d_wdata_i;
      end else begin
        bus.mem_rd_o = 1'b1;
      end
    end else if (fetch_gnt) begin
      bus.mem_addr_o = bus.if_addr_i;
      bus.mem_rd_o   = 1'b1;
    end
  end

  assign bus.if_gnt_o = fetch_gnt;
  assign bus.d_gnt_o  = data_gnt;

  // ---------------------------------------------------------------------------
  // Starvation counter.
  // - Counts cycles where fetch is requesting but not granted.
  // - Holds once it reaches the limit.
  // - Drops to zero whenever fetch is granted or stops requesting.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_next = '0;
    if (bus.if_req_i && !fetch_gnt) begin
      if (starve_reg == STARVE_LIM) begin
        starve_next = starve_reg;
      end else begin
        starve_next = starve_reg + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-owner pipeline: a single stage, matching the one-cycle memory
  // read latency. It is overwritten every cycle, which is what lets
  // back-to-back reads stream with no bubbles.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_valid_next = read_gnt;
    pend_owner_next = data_gnt ? OWN_DATA : OWN_FETCH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_reg     <= '0;
      pend_valid_reg <= 1'b0;
      pend_owner_reg <= OWN_FETCH;
    end else begin
      starve_reg     <= starve_next;
      pend_valid_reg <= pend_valid_next;
      pend_owner_reg <= pend_owner_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port response: rvalid pulse plus the held read-data register.
  // rst_i masks rvalid, so a read granted just before reset is squashed
  // even though its data still arrives from the memory.
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0]  rvalid_port;
  logic [DW-1:0]     rdata_port [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    localparam owner_e PORT_OWNER = (gi == 0) ? OWN_FETCH : OWN_DATA;

    logic [DW-1:0] rdata_reg;

    assign rvalid_port[gi] = pend_valid_reg && !rst_i &&
                             (pend_owner_reg == PORT_OWNER);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_reg <= '0;
      end else if (rvalid_port[gi]) begin
        rdata_reg <= bus.mem_rdata_i;
      end
    end

    // Fresh data is passed straight through on the rvalid cycle. Otherwise
    // the port sees the last value it received, or zero while in reset.
    assign rdata_port[gi] = rst_i           ? '0              :
                            rvalid_port[gi] ? bus.mem_rdata_i :
                                              rdata_reg;
  end

  assign bus.if_rvalid_o = rvalid_port[0];
  assign bus.if_rdata_o  = rdata_port[0];
  assign bus.d_rvalid_o  = rvalid_port[1];
  assign bus.d_rdata_o   = rdata_port[1];

endmodule
